mult_share_arbiter: RTL

Shares one combinational 16x16 wallace_multiplier among NREQ independent requesters with a round-robin grant and a two-stage register pipeline (operand stage, product stage). It sits between requesting datapaths and the multiplier: it registers winning operands, lets the multiplier compute in the following cycle, and returns the 32-bit unsigned product tagged with the requester index over a valid/ready response channel. Sustained throughput is one product per cycle, with full backpressure.

---
 rtl/mult_share_arbiter.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin sharing of one combinational 16x16
// Wallace-tree multiplier among NREQ requesters. There are two register
// stages: S1 holds the granted operands, and S2 holds the product. Products
// return tagged with the requester index over a valid/ready channel.
//
// Handshake rules. Each handshake is valid && ready on the same rising edge.
//   - Request side: req_ready depends combinationally on req_valid.
//   - Response side: rsp_* stay stable while rsp_valid && !rsp_ready.

// Unsigned 16x16 multiplier. Partial products are reduced by layers of 3:2
// carry-save compressors (16 -> 11 -> 8 -> 6 -> 4 -> 3 -> 2 rows), and a
// single carry-propagate add then finishes the result. Every row is 32 bits
// wide. The product fits in 32 bits, so the carries shifted out of the top
// never carry any weight.
module wallace_multiplier (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] p
);

  logic [31:0] l0 [16];
  logic [31:0] l1 [11];
  logic [31:0] l2 [8];
  logic [31:0] l3 [6];
  logic [31:0] l4 [4];
  logic [31:0] l5 [3];
  logic [31:0] l6 [2];

  function automatic logic [31:0] csa_sum(input logic [31:0] x, input logic [31:0] y,
                                          input logic [31:0] z);
    return x ^ y ^ z;
  endfunction

  function automatic logic [31:0] csa_carry(input logic [31:0] x, input logic [31:0] y,
                                            input logic [31:0] z);
    return ((x & y) | (x & z) | (y & z)) << 1;
  endfunction

  // Partial products: row i is a shifted by i when b[i] is set.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      l0[i] = b[i] ? (32'(a) << i) : 32'd0;
    end
  end

  // Layer 1: 16 rows -> 5 compressors plus 1 pass-through row.
  always_comb begin
    for (int g = 0; g < 5; g++) begin
      l1[2*g]   = csa_sum(l0[3*g], l0[3*g+1], l0[3*g+2]);
      l1[2*g+1] = csa_carry(l0[3*g], l0[3*g+1], l0[3*g+2]);
    end
    l1[10] = l0[15];
  end

  // Layer 2: 11 rows -> 3 compressors plus 2 pass-through rows.
  always_comb begin
    for (int g = 0; g < 3; g++) begin
      l2[2*g]   = csa_sum(l1[3*g], l1[3*g+1], l1[3*g+2]);
      l2[2*g+1] = csa_carry(l1[3*g], l1[3*g+1], l1[3*g+2]);
    end
    l2[6] = l1[9];
    l2[7] = l1[10];
  end

  // Layer 3: 8 rows -> 2 compressors plus 2 pass-through rows.
  always_comb begin
    for (int g = 0; g < 2; g++) begin
      l3[2*g]   = csa_sum(l2[3*g], l2[3*g+1], l2[3*g+2]);
      l3[2*g+1] = csa_carry(l2[3*g], l2[3*g+1], l2[3*g+2]);
    end
    l3[4] = l2[6];
    l3[5] = l2[7];
  end

  // Layer 4: 6 rows -> 2 compressors.
  always_comb begin
    for (int g = 0; g < 2; g++) begin
      l4[2*g]   = csa_sum(l3[3*g], l3[3*g+1], l3[3*g+2]);
      l4[2*g+1] = csa_carry(l3[3*g], l3[3*g+1], l3[3*g+2]);
    end
  end

  // Layer 5: 4 rows -> 1 compressor plus 1 pass-through row.
  always_comb begin
    l5[0] = csa_sum(l4[0], l4[1], l4[2]);
    l5[1] = csa_carry(l4[0], l4[1], l4[2]);
    l5[2] = l4[3];
  end

  // Layer 6: 3 rows -> the final sum/carry pair.
  always_comb begin
    l6[0] = csa_sum(l5[0], l5[1], l5[2]);
    l6[1] = csa_carry(l5[0], l5[1], l5[2]);
  end

  // The final carry-propagate addition.
  always_comb begin
    p = l6[0] + l6[1];
  end

endmodule

module mult_share_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*WIDTH-1:0]     req_a,
  input  logic [NREQ*WIDTH-1:0]     req_b,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic [2*WIDTH-1:0]        rsp_prod,
  output logic                      busy
);

  localparam int IDW = $clog2(NREQ);
  localparam int PW  = 2 * WIDTH;

  // Round-robin pointer: the requester that is searched first.
  logic [IDW-1:0]   ptr;

  // S1: the operand register.
  logic             v1;
  logic [IDW-1:0]   id1;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;

  // S2: the product register.
  logic             v2;
  logic [IDW-1:0]   id2;
  logic [PW-1:0]    p2;

  logic             adv1;
  logic             adv2;
  logic             accept1;
  logic             found;
  logic [IDW-1:0]   win;
  logic             hs;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [PW-1:0]    mult_p;

  assign adv2    = !v2 || rsp_ready;
  assign adv1    = v1 && adv2;
  assign accept1 = !v1 || adv1;

  // Winner search: the first valid requester, starting at ptr and wrapping
  // modulo NREQ. IDW-bit addition wraps naturally because NREQ is a power of two.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_valid[IDW'(ptr + IDW'(k))]) begin
        found = 1'b1;
        win   = IDW'(ptr + IDW'(k));
      end
    end
  end

  // Grant only the winner, and only when S1 can take a new entry.
  // Gating with rst_n keeps every grant low while reset is asserted.
  assign hs = rst_n && found && accept1;

  // Drive the one-hot request acceptance from the handshake decision.
  always_comb begin
    req_ready = '0;
    if (hs) begin
      req_ready[win] = 1'b1;
    end
  end

  assign sel_a = req_a[32'(win)*WIDTH +: WIDTH];
  assign sel_b = req_b[32'(win)*WIDTH +: WIDTH];

  wallace_multiplier u_mult (
    .a (a1),
    .b (b1),
    .p (mult_p)
  );

  // Arbiter pointer: move past the winner only when a handshake happens.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (hs) begin
      ptr <= win + IDW'(1);
    end
  end

  // S1: load on a handshake, empty when the entry moves on with no
  // replacement, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1  <= 1'b0;
      id1 <= '0;
      a1  <= '0;
      b1  <= '0;
    end else if (hs) begin
      v1  <= 1'b1;
      id1 <= win;
      a1  <= sel_a;
      b1  <= sel_b;
    end else if (adv1) begin
      v1  <= 1'b0;
    end
  end

  // S2: capture the multiplier output whenever S2 is empty or being consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2  <= 1'b0;
      id2 <= '0;
      p2  <= '0;
    end else if (adv2) begin
      v2  <= v1;
      id2 <= id1;
      p2  <= mult_p;
    end
  end

  assign rsp_valid = v2;
  assign rsp_id    = id2;
  assign rsp_prod  = p2;
  assign busy      = v1 || v2;

endmodule
